// File: rtl/ysyx_25050148_lsu_pkg.sv
// Shared LSU definitions: funct3 encodings, FSM states and access-size helpers.
package ysyx_25050148_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [2:0] {
        S_IDLE, S_ACC0, S_WAIT0, S_ACC1, S_WAIT1, S_RESP
    } lsu_state_e;

    function automatic logic [3:0] base_mask(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [2:0] acc_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic f3_legal(input logic wen, input logic [2:0] f3);
        if (wen) return f3 inside {F3_SB, F3_SH, F3_SW};
        return f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
    endfunction

endpackage

// File: rtl/ysyx_25050148_lsu_if.sv
// EXU<->LSU request/response channel and LSU<->memory transaction channel.
interface ysyx_25050148_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [2:0]  req_func3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (output req_valid, req_wen, req_func3, req_addr, req_wdata, resp_ready,
                    input  req_ready, resp_valid, resp_rdata, resp_err);
    modport slave  (input  req_valid, req_wen, req_func3, req_addr, req_wdata, resp_ready,
                    output req_ready, resp_valid, resp_rdata, resp_err);
endinterface

interface ysyx_25050148_mem_if;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic        mem_resp_valid;
    logic [31:0] mem_rdata;

    modport master (output mem_req_valid, mem_wen, mem_addr, mem_wmask, mem_wdata,
                    input  mem_req_ready, mem_resp_valid, mem_rdata);
    modport slave  (input  mem_req_valid, mem_wen, mem_addr, mem_wmask, mem_wdata,
                    output mem_req_ready, mem_resp_valid, mem_rdata);
endinterface

// File: rtl/ysyx_25050148_lsu_align.sv
// Byte-lane alignment: store mask/data placement over two words, load extraction and extension.
module ysyx_25050148_lsu_align
    import ysyx_25050148_pkg::*;
(
    input  logic [1:0]  sh,
    input  logic [2:0]  func3,
    input  logic [31:0] wdata,
    input  logic [31:0] r0,
    input  logic [31:0] r1,
    output logic [7:0]  m8,
    output logic [63:0] d64,
    output logic [31:0] ldata
);

    logic [63:0] w64;
    logic [31:0] w;

    assign m8  = {4'b0000, base_mask(func3)} << sh;
    assign d64 = {32'b0, wdata} << {sh, 3'b000};
    assign w64 = {r1, r0} >> {sh, 3'b000};
    assign w   = w64[31:0];

    always_comb begin
        ldata = '0;
        case (func3)
            F3_LB:   ldata = {{24{w[7]}}, w[7:0]};
            F3_LH:   ldata = {{16{w[15]}}, w[15:0]};
            F3_LW:   ldata = w;
            F3_LBU:  ldata = {24'b0, w[7:0]};
            F3_LHU:  ldata = {16'b0, w[15:0]};
            default: ldata = '0;
        endcase
    end

endmodule

// File: rtl/ysyx_25050148_lsu.sv
// Multi-cycle load/store unit; misaligned accesses become two aligned word transactions.
module ysyx_25050148_lsu
    import ysyx_25050148_pkg::*;
#(
    parameter int ALLOW_MISALIGNED = 1,
    parameter int RESP_TIMEOUT     = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    ysyx_25050148_lsu_if.slave        exu,
    ysyx_25050148_mem_if.master       mem
);

    localparam int CW = (RESP_TIMEOUT > 0) ? $clog2(RESP_TIMEOUT + 1) : 1;

    lsu_state_e  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  func3_q, func3_d;
    logic        wen_q, wen_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] r0_q, r0_d;
    logic [31:0] r1_q, r1_d;
    logic        err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [7:0]  m8;
    logic [63:0] d64;
    logic [31:0] ldata;
    logic [31:0] a0, a1;
    logic        need2, in_mis, to_hit, in_acc0, in_acc1;

    ysyx_25050148_lsu_align u_align (
        .sh    (addr_q[1:0]),
        .func3 (func3_q),
        .wdata (wdata_q),
        .r0    (r0_q),
        .r1    (r1_q),
        .m8    (m8),
        .d64   (d64),
        .ldata (ldata)
    );

    assign a0     = {addr_q[31:2], 2'b00};
    assign a1     = a0 + 32'd4;
    assign need2  = |m8[7:4];
    // The incoming request is checked before capture, so use the size arithmetic directly.
    assign in_mis = ({1'b0, exu.req_addr[1:0]} + acc_size(exu.req_func3)) > 3'd4;
    assign to_hit = (RESP_TIMEOUT != 0) && (cnt_q == CW'(RESP_TIMEOUT));

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        func3_d = func3_q;
        wen_d   = wen_q;
        wdata_d = wdata_q;
        r0_d    = r0_q;
        r1_d    = r1_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: if (exu.req_valid) begin
                addr_d  = exu.req_addr;
                func3_d = exu.req_func3;
                wen_d   = exu.req_wen;
                wdata_d = exu.req_wdata;
                r0_d    = '0;
                r1_d    = '0;
                err_d   = 1'b0;
                if (!f3_legal(exu.req_wen, exu.req_func3) || (ALLOW_MISALIGNED == 0 && in_mis)) begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    state_d = S_ACC0;
                end
            end
            S_ACC0: if (mem.mem_req_ready) begin
                cnt_d   = '0;
                state_d = S_WAIT0;
            end
            S_WAIT0: begin
                if (mem.mem_resp_valid) begin
                    r0_d    = mem.mem_rdata;
                    state_d = need2 ? S_ACC1 : S_RESP;
                end else if (to_hit) begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_ACC1: if (mem.mem_req_ready) begin
                cnt_d   = '0;
                state_d = S_WAIT1;
            end
            S_WAIT1: begin
                if (mem.mem_resp_valid) begin
                    r1_d    = mem.mem_rdata;
                    state_d = S_RESP;
                end else if (to_hit) begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RESP: if (exu.resp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            func3_q <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            r0_q    <= '0;
            r1_q    <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            func3_q <= func3_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            r0_q    <= r0_d;
            r1_q    <= r1_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // All outputs decode from state so an async reset drops them immediately.
    assign in_acc0 = (state_q == S_ACC0);
    assign in_acc1 = (state_q == S_ACC1);

    assign exu.req_ready  = (state_q == S_IDLE);
    assign exu.resp_valid = (state_q == S_RESP);
    assign exu.resp_err   = (state_q == S_RESP) && err_q;
    assign exu.resp_rdata = ((state_q == S_RESP) && !err_q && !wen_q) ? ldata : 32'h0;

    assign mem.mem_req_valid = in_acc0 || in_acc1;
    assign mem.mem_wen       = (in_acc0 || in_acc1) && wen_q;
    assign mem.mem_addr      = in_acc0 ? a0 : (in_acc1 ? a1 : 32'h0);
    assign mem.mem_wmask     = !wen_q ? 4'h0 : (in_acc0 ? m8[3:0] : (in_acc1 ? m8[7:4] : 4'h0));
    assign mem.mem_wdata     = !wen_q ? 32'h0 : (in_acc0 ? d64[31:0] : (in_acc1 ? d64[63:32] : 32'h0));

endmodule

// File: doc/ysyx_25050148_lsu.md
Name: ysyx_25050148_lsu

Overview:
Multi-cycle load/store unit placed between the execute stage and the DPI-backed data memory port. It accepts one load or store per handshake and produces aligned byte-lane memory transactions. Misaligned accesses are split into two aligned word transactions. Load data is returned already extracted and sign- or zero-extended per func3, so writeback consumes it directly.

Parameters:
ALLOW_MISALIGNED, 1, 1 = split misaligned accesses into two transactions; 0 = answer misaligned accesses with resp_err and issue no memory access.
RESP_TIMEOUT, 255, number of cycles to wait for mem_resp_valid before answering with resp_err; 0 disables the timeout.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
req_valid  in  1  EXU request valid
req_ready  out  1  LSU can accept a request (IDLE only)
req_wen  in  1  1 = store, 0 = load
req_func3  in  3  RISC-V funct3: loads 000/001/010/100/101; stores 000/001/010
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned
resp_valid  out  1  result valid; held until resp_ready
resp_ready  in  1  writeback accepts the result
resp_rdata  out  32  extended load data; 0 for stores
resp_err  out  1  illegal func3, misaligned with ALLOW_MISALIGNED=0, or timeout
mem_req_valid  out  1  memory transaction valid
mem_req_ready  in  1  memory accepts the transaction
mem_wen  out  1  1 = write
mem_addr  out  32  word-aligned address (bits [1:0] = 00)
mem_wmask  out  4  byte-lane write mask, bit i = byte i
mem_wdata  out  32  lane-positioned write data
mem_resp_valid  in  1  read data valid, or write acknowledge
mem_rdata  in  32  aligned word read data

Behaviour:
Reset:
- States and valids: state=IDLE; req_ready=1; resp_valid=0; mem_req_valid=0.
- Data outputs: resp_rdata=0, resp_err=0, mem_addr=0, mem_wmask=0, mem_wdata=0, mem_wen=0.

Request capture:
- A request is accepted when req_valid & req_ready, in IDLE only.
- On acceptance, addr, func3, wen and wdata are captured. Port inputs are ignored until the LSU returns to IDLE.

Derived values:
- sh = addr[1:0].
- A0 = {addr[31:2], 2'b00}; A1 = A0 + 4, wrapping mod 2^32 (0xFFFFFFFC -> 0x00000000).
- Size: 1 byte for func3 000/100, 2 bytes for 001/101, 4 bytes for 010.
- Base mask: byte 0001, half 0011, word 1111.
- M8 = {4'b0, base} << sh (8 bits). D64 = {32'b0, wdata} << (8*sh) (64 bits).
- Access 0 uses M8[3:0] and D64[31:0]. Access 1 uses M8[7:4] and D64[63:32].
- need2 = (M8[7:4] != 0), which equals misaligned. Bytes are never misaligned.

Illegal or disallowed requests:
- Covered cases: loads with func3 011/110/111, stores with func3 >= 011, and need2 with ALLOW_MISALIGNED=0.
- These go IDLE -> RESP with resp_err=1 and resp_rdata=0. No mem_req is issued.

State machine (IDLE, ACC0, WAIT0, ACC1, WAIT1, RESP):
- IDLE: on accept, go to ACC0, or RESP for an error.
- ACC0: mem_req_valid=1, addr A0, mask M8[3:0] (reads drive mask 0). On mem_req_ready, go to WAIT0.
- WAIT0: on mem_resp_valid, latch R0=mem_rdata. Go to ACC1 if need2, else RESP.
- ACC1 / WAIT1: same as ACC0 / WAIT0 with A1 and M8[7:4]; latch R1. WAIT1 -> RESP.
- RESP: resp_valid=1. On resp_ready, go to IDLE.
- mem_req_valid and its payload stay stable while mem_req_valid=1 & !mem_req_ready.

Load extraction:
- W = ({R1, R0} >> (8*sh))[31:0], with R1=0 when not need2.
- Extension per func3: lb sign-extends W[7:0]; lh sign-extends W[15:0]; lw uses W; lbu/lhu zero-extend.

Latency and throughput:
- Aligned access with mem_req_ready=1 and a 1-cycle memory response: accept at edge T, mem_req_valid during T+1, mem_resp_valid during T+2, resp_valid during T+3.
- Split access adds 2 cycles.
- One request in flight; no pipelining.

Boundary conditions:
- mem_resp_valid outside WAIT0/WAIT1 is ignored.
- Timeout: a counter is cleared on entering WAIT0/WAIT1. When it reaches RESP_TIMEOUT, go to RESP with resp_err=1 and abandon the second access.
- Asynchronous reset mid-transaction returns to IDLE immediately and drops all valids. A store split in flight may already have committed its first half; this is accepted behaviour.

Decomposition:
- Shared package ysyx_25050148_pkg holds:
  - func3 constants (LB/LH/LW/LBU/LHU, SB/SH/SW);
  - state enum;
  - base-mask and size functions.
- Sub-module ysyx_25050148_lsu_align: purely combinational. It computes M8 and D64 on stores, and W plus extension on loads, shared by both paths.

Test Plan:
- Aligned lw at 0x80000010, mem word 0xDEADBEEF -> one transaction at 0x80000010, mask 0000; resp_rdata=0xDEADBEEF, resp_err=0, resp_valid 3 cycles after accept.
- lb at 0x80000013 with word 0x80FF1122 -> resp_rdata=0xFFFFFF80; lbu on the same request -> 0x00000080.
- sw 0x11223344 at 0x80000002 -> first transaction addr 0x80000000, mask 1100, data 0x33440000; second transaction addr 0x80000004, mask 0011, data 0x00001122.
- lh at 0xFFFFFFFF, bytes 0xAB at 0xFFFFFFFF and 0xCD at 0x00000000 -> addresses 0xFFFFFFFC then 0x00000000; resp_rdata=0xFFFFCDAB.
- func3=011 load, or ALLOW_MISALIGNED=0 with lw at 0x1 -> resp_err=1, no mem_req_valid; a memory that never asserts mem_resp_valid -> resp_err=1 after RESP_TIMEOUT cycles.
- rst asserted while in WAIT0 with resp_ready=0 backpressure -> outputs drop to reset values asynchronously; a late mem_resp_valid is ignored; the next request completes normally.
